dmem_responder: RTL and testbench

//  - Data-memory responder: the target end of the load/store request interface driven by the pipeline's memory stage.
//  - Accepts one request at a time, inserts a fixed number of wait states, then returns read data or a store acknowledgement.
//  - Replaces the zero-latency data memory so stall and handshake paths in the pipeline are exercised.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_array.sv | 35 +++
 rtl/dmem_responder.sv | 148 ++++++++++++++
 tb/tb_dmem_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// byte-enable constants and the legal byte-enable lookup table.
package dmem_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] BYTE_EN_FULL = 4'hF;

    // Entry [off] is a 16-bit mask indexed by the byte-enable value.
    // A set bit means that byte-enable pattern is a naturally aligned
    // byte/halfword/word access starting at byte offset off.
    //   off 0: 1, 3, F   off 1: 2   off 2: 4, C   off 3: 8
    localparam logic [3:0][15:0] LEGAL_BE = {16'h0100, 16'h1010, 16'h0004, 16'h800A};

    function automatic logic be_legal(input logic [1:0] off, input logic [3:0] be);
        return LEGAL_BE[off][be];
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word storage with per-byte write enables and a
// registered read port. Contents are never cleared; the read register only
// updates on an enabled load, so it holds the last load result.
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        be,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Byte-masked write on stores, registered full-word read on loads
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits
// WAIT_CYCLES, then presents the response until the requester takes it.
// Optional feature macro: DMEM_MISALIGN_ERR_EN flags misaligned loads and
// illegal store byte-enables with rsp_err and suppresses the store.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    import dmem_pkg::*;

    localparam int ADDR_W = $clog2(DEPTH_WORDS);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              err_q, err_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_err_q, rsp_err_d;

    logic              idle, commit, req_err;
    logic              cur_we, cur_err;
    logic [ADDR_W-1:0] cur_idx;
    logic [31:0]       cur_wdata;
    logic [3:0]        cur_be;
    logic [31:0]       arr_rdata;

    // Address bits outside the word index are intentionally ignored
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

    // Alignment check on the incoming request
    always_comb begin
        req_err = 1'b0;
`ifdef DMEM_MISALIGN_ERR_EN
        req_err = req_we ? !be_legal(req_addr[1:0], req_be) : (req_addr[1:0] != 2'b00);
`endif
    end

    // Select the live request in IDLE (needed when WAIT_CYCLES=0 commits on
    // the accept edge), otherwise the latched one
    always_comb begin
        idle      = (state_q == IDLE);
        cur_we    = idle ? req_we                  : we_q;
        cur_idx   = idle ? req_addr[ADDR_W+1:2]    : idx_q;
        cur_wdata = idle ? req_wdata               : wdata_q;
        cur_be    = idle ? req_be                  : be_q;
        cur_err   = idle ? req_err                 : err_q;
        commit    = (state_q == WAIT && cnt_q == 4'd1) ||
                    (idle && req_valid && WAIT_CYCLES == 0);
    end

    // FSM, wait counter, request latch and response flags
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        err_d      = err_q;
        rsp_zero_d = rsp_zero_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                we_d    = req_we;
                idx_d   = req_addr[ADDR_W+1:2];
                wdata_d = req_wdata;
                be_d    = req_be;
                err_d   = req_err;
                cnt_d   = 4'(WAIT_CYCLES);
                state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = RESP;
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Response payload is fixed on the edge entering RESP
        if (commit) begin
            rsp_zero_d = cur_we || cur_err;
            rsp_err_d  = cur_err;
        end
    end

    // State registers; reset drops any pending request/response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            err_q      <= 1'b0;
            rsp_zero_q <= 1'b1;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            err_q      <= err_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Storage access happens exactly once, on the edge entering RESP; a
    // reset on that edge cancels the write
    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_array (
        .clk   (clk),
        .en    (commit && !rst),
        .we    (cur_we && !cur_err),
        .addr  (cur_idx),
        .wdata (cur_wdata),
        .be    (cur_be),
        .rdata (arr_rdata)
    );

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_zero_q ? 32'd0 : arr_rdata;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (DEPTH_WORDS=1024, WAIT_CYCLES=2).
// Reference model: a small word array over the low 16 words plus rules for
// latency and alignment errors. Honours DMEM_MISALIGN_ERR_EN when defined.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int WAITC = 2;

    logic        clk, rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [16];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Alignment rule: loads must be word aligned; stores must be a
    // naturally aligned byte, halfword or word starting at the offset.
    function automatic bit exp_err(input bit we, input logic [1:0] off, input logic [3:0] be);
`ifdef DMEM_MISALIGN_ERR_EN
        int sz;
        int m;
        sz = $countones(be);
        if (!we) return off != 2'd0;
        if (!(sz == 1 || sz == 2 || sz == 4)) return 1'b1;
        if ((int'(off) % sz) != 0) return 1'b1;
        m = ((1 << sz) - 1) << off;
        return be != m[3:0];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_rd(input bit we, input logic [31:0] addr, input logic [3:0] be);
        if (we || exp_err(we, addr[1:0], be)) return 32'd0;
        return mdl[addr[5:2]];
    endfunction

    task automatic mdl_apply(input bit we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        if (we && !exp_err(we, addr[1:0], be))
            for (int i = 0; i < 4; i++) if (be[i]) mdl[addr[5:2]][8*i +: 8] = wd[8*i +: 8];
    endtask

    // One transaction from IDLE; called at a negedge, returns at a negedge
    task automatic xact(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int bp,
                        output logic [31:0] rd, output logic er, output int lat,
                        output bit timeout, output bit stable, output bit rdy_after);
        timeout = 0; stable = 1; rdy_after = 0; lat = 0; rd = '0; er = 0;
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        @(posedge clk); lat = 1;
        @(negedge clk);
        // keep junk on the request bus; it must not be accepted
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
        while (!rsp_valid && lat < 64) begin @(posedge clk); lat++; @(negedge clk); end
        if (!rsp_valid) begin timeout = 1; req_valid = 0; return; end
        rd = rsp_rdata; er = rsp_err;
        if (req_ready !== 1'b0) stable = 0;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er || req_ready !== 1'b0) stable = 0;
        end
        rsp_ready = 1;
        @(posedge clk); @(negedge clk);
        rsp_ready = 0; req_valid = 0;
        rdy_after = (req_ready === 1'b1) && (rsp_valid === 1'b0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    bit          to, st, ra;

    task automatic test_reset;
        rst = 1; req_valid = 0; rsp_ready = 0; req_we = 0;
        req_addr = 0; req_wdata = 0; req_be = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    endtask

    task automatic test_store_load;
        xact(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, to, st, ra);
        mdl_apply(1, 32'h10, 32'hDEADBEEF, 4'hF);
        checks++; if (to || lat != WAITC + 1) begin errors++; $display("FAIL store_latency: got %0d (timeout %0d) want %0d", lat, to, WAITC + 1); end
        checks++; if (rd !== 32'd0 || er !== 1'b0) begin errors++; $display("FAIL store_rsp: got rdata %h err %b want 0/0", rd, er); end
        xact(0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, to, st, ra);
        checks++; if (to || lat != WAITC + 1) begin errors++; $display("FAIL load_latency: got %0d want %0d", lat, WAITC + 1); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data: got %h want deadbeef", rd); end
        checks++; if (!ra) begin errors++; $display("FAIL back_to_back_ready: got 0 want 1 after handshake"); end
    endtask

    task automatic test_byte_enable;
        xact(1, 32'h10, 32'h000000AA, 4'h1, 0, rd, er, lat, to, st, ra);
        mdl_apply(1, 32'h10, 32'h000000AA, 4'h1);
        xact(0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, to, st, ra);
        checks++; if (to || rd !== 32'hDEADBEAA) begin errors++; $display("FAIL byte_enable: got %h want deadbeaa", rd); end
    endtask

    task automatic test_backpressure;
        xact(0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat, to, st, ra);
        checks++; if (to || !st) begin errors++; $display("FAIL backpressure_stable: got stable=%0d timeout=%0d want 1/0", st, to); end
        checks++; if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL backpressure_data: got %h want deadbeaa", rd); end
        checks++; if (!ra) begin errors++; $display("FAIL backpressure_complete: got ready=0 want 1 after handshake"); end
    endtask

    task automatic test_wrap;
        xact(0, 32'h10 + DEPTH * 4, 32'h0, 4'h0, 0, rd, er, lat, to, st, ra);
        checks++; if (to || rd !== 32'hDEADBEAA) begin errors++; $display("FAIL wrap_load: got %h want deadbeaa", rd); end
    endtask

    task automatic test_mid_reset;
        xact(1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat, to, st, ra);
        mdl_apply(1, 32'h20, 32'h11223344, 4'hF);
        req_valid = 1; req_we = 1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
        @(posedge clk);
        @(negedge clk); req_valid = 0; rst = 1;
        @(posedge clk);
        @(negedge clk); rst = 0;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset_idle: got ready %b valid %b want 1/0", req_ready, rsp_valid); end
        xact(0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, to, st, ra);
        checks++; if (to || rd !== 32'h11223344) begin errors++; $display("FAIL midreset_mem: got %h want 11223344", rd); end
    endtask

    task automatic test_misalign;
        logic [31:0] e;
        e = exp_rd(0, 32'h11, 4'h0);
        xact(0, 32'h11, 32'h0, 4'h0, 0, rd, er, lat, to, st, ra);
        checks++; if (to || rd !== e || er !== exp_err(0, 2'd1, 4'h0)) begin errors++; $display("FAIL misalign_load: got %h/%b want %h/%b", rd, er, e, exp_err(0, 2'd1, 4'h0)); end
        xact(1, 32'h20, 32'hCAFEF00D, 4'h6, 0, rd, er, lat, to, st, ra);
        mdl_apply(1, 32'h20, 32'hCAFEF00D, 4'h6);
        checks++; if (to || er !== exp_err(1, 2'd0, 4'h6) || lat != WAITC + 1) begin errors++; $display("FAIL misalign_store: got err %b lat %0d want %b/%0d", er, lat, exp_err(1, 2'd0, 4'h6), WAITC + 1); end
        e = mdl[8];
        xact(0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, to, st, ra);
        checks++; if (to || rd !== e) begin errors++; $display("FAIL misalign_mem: got %h want %h", rd, e); end
    endtask

    task automatic test_random;
        bit          we;
        logic [31:0] addr, wd, e;
        logic [3:0]  be;
        int          bp;
        bit          ee;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            xact(1, 32'(i * 4), wd, 4'hF, 0, rd, er, lat, to, st, ra);
            mdl_apply(1, 32'(i * 4), wd, 4'hF);
        end
        for (int n = 0; n < 60; n++) begin
            we   = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3) + $urandom_range(0, 3) * DEPTH * 4);
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'd0;
            be   = 4'($urandom_range(0, 15));
            wd   = $urandom;
            bp   = $urandom_range(0, 3);
            e    = exp_rd(we, addr, be);
            ee   = exp_err(we, addr[1:0], be);
            xact(we, addr, wd, be, bp, rd, er, lat, to, st, ra);
            mdl_apply(we, addr, wd, be);
            checks++;
            if (to || rd !== e || er !== ee || lat != WAITC + 1 || !st || !ra) begin
                errors++;
                $display("FAIL random_op%0d we=%0d addr=%h be=%h: got rd %h err %b lat %0d st %0d ra %0d want rd %h err %b lat %0d st 1 ra 1",
                         n, we, addr, be, rd, er, lat, st, ra, e, ee, WAITC + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_enable();
        test_backpressure();
        test_wrap();
        test_mid_reset();
        test_misalign();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
